// File: rtl/coin_input_conditioner.sv
// Coin button front end: sync, debounce, press detect, lock/pending gating, one-hot arbiter.
// Define COIN_COUNT_EN to add saturating per-coin pulse counters (cnt_50/cnt_100/cnt_200).
module coin_input_conditioner #(
  parameter int CLK_FREQ       = 50_000_000,
  parameter int DEBOUNCE_MS    = 10,
  parameter bit BTN_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_50,
  input  logic       btn_100,
  input  logic       btn_200,
  input  logic       lock,
  output logic       r50,
  output logic       r100,
  output logic       r200,
  output logic       reject
`ifdef COIN_COUNT_EN
  ,
  output logic [7:0] cnt_50,
  output logic [7:0] cnt_100,
  output logic [7:0] cnt_200
`endif
);

  localparam longint DC_RAW =
    longint'(CLK_FREQ) * longint'(DEBOUNCE_MS) / 64'sd1000;
  localparam int DEBOUNCE_CYCLES =
    (DC_RAW < 64'sd1) ? 1 : int'(DC_RAW);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0] REL =
    BTN_ACTIVE_LOW ? 3'b111 : 3'b000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  // channel index: 0 = 50, 1 = 100, 2 = 200
  logic [2:0]       btn_raw;
  logic [2:0]       sync1;
  logic [2:0]       sync2;
  logic [2:0]       lvl;
  logic [2:0]       deb;
  logic [2:0]       deb_d;
  logic [CNT_W-1:0] db_cnt [3];
  logic [2:0]       press;
  logic [2:0]       discard;
  logic [2:0]       accept;
  logic [2:0]       pend;
  logic [2:0]       grant;
  state_t           state;
  state_t           state_n;

  assign btn_raw = {btn_200, btn_100, btn_50};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= REL;
      sync2 <= REL;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  assign lvl = BTN_ACTIVE_LOW ? ~sync2 : sync2;

  // counter reaching DEBOUNCE_CYCLES is the cycle it would hit CNT_MAX+1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb   <= '0;
      deb_d <= '0;
      for (int i = 0; i < 3; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      deb_d <= deb;
      for (int i = 0; i < 3; i++) begin
        if (lvl[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_MAX) begin
          db_cnt[i] <= '0;
          deb[i]    <= ~deb[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign press   = deb & ~deb_d;
  assign discard = press & (lock ? 3'b111 : pend);
  assign accept  = press & ~discard;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend   <= '0;
      reject <= 1'b0;
    end else begin
      pend   <= (pend & ~grant) | accept;
      reject <= |discard;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      r50   <= 1'b0;
      r100  <= 1'b0;
      r200  <= 1'b0;
    end else begin
      state <= state_n;
      r50   <= grant[0];
      r100  <= grant[1];
      r200  <= grant[2];
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (|pend) state_n = PULSE;
      PULSE:   state_n = GAP;
      GAP:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    grant = '0;
    if (state == IDLE) begin
      if (pend[2])      grant = 3'b100;
      else if (pend[1]) grant = 3'b010;
      else if (pend[0]) grant = 3'b001;
    end
  end

`ifdef COIN_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_50  <= '0;
      cnt_100 <= '0;
      cnt_200 <= '0;
    end else begin
      if (grant[0] && cnt_50 != 8'hff)
        cnt_50 <= cnt_50 + 8'd1;
      if (grant[1] && cnt_100 != 8'hff)
        cnt_100 <= cnt_100 + 8'd1;
      if (grant[2] && cnt_200 != 8'hff)
        cnt_200 <= cnt_200 + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Scoreboard bench for coin_input_conditioner (DEBOUNCE_CYCLES = 4).
// Stimulus pushes {reject,r200,r100,r50} + expected cycle; monitor pops on any output.
module tb_coin_input_conditioner;

  localparam int LAT  = 8;
  localparam int RLAT = 7;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_50, btn_100, btn_200, lock;
  logic r50, r100, r200, reject;
`ifdef COIN_COUNT_EN
  logic [7:0] cnt_50, cnt_100, cnt_200;
`endif

  typedef struct {
    int         cyc;
    logic [3:0] code;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  coin_input_conditioner #(
    .CLK_FREQ(1000),
    .DEBOUNCE_MS(4),
    .BTN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_50(btn_50),
    .btn_100(btn_100),
    .btn_200(btn_200),
    .lock(lock),
    .r50(r50),
    .r100(r100),
    .r200(r200),
    .reject(reject)
`ifdef COIN_COUNT_EN
    ,
    .cnt_50(cnt_50),
    .cnt_100(cnt_100),
    .cnt_200(cnt_200)
`endif
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [3:0] code, input int dly);
    exp_t e;
    e.code = code;
    e.cyc  = cyc + dly;
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic monitor_loop();
    logic [3:0] obs;
    exp_t       e;
    forever begin
      @(negedge clk);
      obs = {reject, r200, r100, r50};
      if (q.size() > 0 && q[0].cyc < cyc) begin
        n_vec++;
        n_err++;
        $display("FAIL missing: code %b due cyc %0d, now %0d",
                 q[0].code, q[0].cyc, cyc);
        q.delete(0);
      end
      if (obs != 4'b0000) begin
        n_vec++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected: got %b at cyc %0d, want none",
                   obs, cyc);
        end else begin
          e = q.pop_front();
          if (e.code !== obs || e.cyc != cyc) begin
            n_err++;
            $display("FAIL pulse: got %b at cyc %0d, want %b at %0d",
                     obs, cyc, e.code, e.cyc);
          end
        end
      end
    end
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_r50"}, 32'(r50), 0);
    chk({nm, "_r100"}, 32'(r100), 0);
    chk({nm, "_r200"}, 32'(r200), 0);
    chk({nm, "_reject"}, 32'(reject), 0);
  endtask

  initial begin
    rst_n   = 1'b0;
    btn_50  = 1'b1;
    btn_100 = 1'b1;
    btn_200 = 1'b1;
    lock    = 1'b0;
    tick(3);
    chk_idle("reset");
    fork
      monitor_loop();
    join_none
    rst_n = 1'b1;
    tick(5);

    // clean 100 press, held, then released
    btn_100 = 1'b0;
    push(4'b0010, LAT);
    tick(20);
    btn_100 = 1'b1;
    tick(20);

    // bouncing 50, then stable low
    for (int i = 0; i < 6; i++) begin
      btn_50 = (i % 2 == 1);
      tick(2);
    end
    btn_50 = 1'b0;
    push(4'b0001, LAT);
    tick(20);
    btn_50 = 1'b1;
    tick(20);

    // simultaneous: 200, 100, 50 in 3-cycle slots
    btn_50  = 1'b0;
    btn_100 = 1'b0;
    btn_200 = 1'b0;
    push(4'b0100, LAT);
    push(4'b0010, LAT + 3);
    push(4'b0001, LAT + 6);
    tick(25);
    btn_50  = 1'b1;
    btn_100 = 1'b1;
    btn_200 = 1'b1;
    tick(20);

    // locked press rejected, unlocked press accepted
    lock    = 1'b1;
    btn_200 = 1'b0;
    push(4'b1000, RLAT);
    tick(12);
    btn_200 = 1'b1;
    tick(12);
    lock = 1'b0;
    tick(2);
    btn_200 = 1'b0;
    push(4'b0100, LAT);
    tick(20);
    btn_200 = 1'b1;
    tick(20);

    // reset drops a coin in flight
    btn_100 = 1'b0;
    tick(5);
    rst_n   = 1'b0;
    btn_100 = 1'b1;
    tick(1);
    chk_idle("in_reset");
    tick(1);
    rst_n = 1'b1;
    tick(20);
    chk_idle("post_reset");
    btn_100 = 1'b0;
    push(4'b0010, LAT);
    tick(20);
    btn_100 = 1'b1;
    tick(20);

`ifdef COIN_COUNT_EN
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(5);
    chk("cnt_50_rst", 32'(cnt_50), 0);
    for (int i = 0; i < 4; i++) begin
      if (i < 3) btn_50 = 1'b0;
      else btn_200 = 1'b0;
      push(i < 3 ? 4'b0001 : 4'b0100, LAT);
      tick(10);
      btn_50  = 1'b1;
      btn_200 = 1'b1;
      tick(10);
    end
    chk("cnt_50", 32'(cnt_50), 3);
    chk("cnt_100", 32'(cnt_100), 0);
    chk("cnt_200", 32'(cnt_200), 1);
    for (int i = 0; i < 256; i++) begin
      btn_50 = 1'b0;
      push(4'b0001, LAT);
      tick(10);
      btn_50 = 1'b1;
      tick(10);
    end
    chk("cnt_50_sat", 32'(cnt_50), 255);
`endif

    tick(5);
    chk("queue_empty", 32'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/coin_input_conditioner.md
Name: coin_input_conditioner

Overview:
- Upstream stage of the coffee vending FSM. Takes raw board push-buttons for 50/100/200 coins and delivers clean single-cycle pulses on r50/r100/r200.
- Per button: synchronises, debounces and edge-detects the input.
- Arbitrates simultaneous coins so the FSM sees at most one one-hot pulse per delivery slot.
- Rejects coins while the FSM signals it is busy (DELAY state).

Parameters:
- CLK_FREQ, 50_000_000, clock frequency in Hz. Same meaning as the FSM's CLK_FREQ.
- DEBOUNCE_MS, 10, required stable time in ms.
- BTN_ACTIVE_LOW, 1, 1 = a button reads 0 when pressed.
- localparam DEBOUNCE_CYCLES = max(1, CLK_FREQ*DEBOUNCE_MS/1000).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active-low
- btn_50  in  1  raw button, 50 coin (asynchronous, bouncing)
- btn_100  in  1  raw button, 100 coin
- btn_200  in  1  raw button, 200 coin
- lock  in  1  1 = downstream busy (FSM state_o==2'b11); new coins are rejected
- r50  out  1  one-cycle pulse, 50 accepted
- r100  out  1  one-cycle pulse, 100 accepted
- r200  out  1  one-cycle pulse, 200 accepted
- reject  out  1  one-cycle pulse, one or more coin events discarded this cycle

Behaviour:
- Reset (rst_n=0, async):
  - Sync flops go to the released level (1 if BTN_ACTIVE_LOW, else 0).
  - Debounced states = released; debounce counters = 0; pending flags = 0.
  - Arbiter FSM = IDLE; r50/r100/r200/reject = 0.
- Sync: 2-flop synchroniser per button, then normalise to pressed=1.
- Debounce, per channel:
  - While synced level != debounced state, the counter increments; any cycle where they are equal clears it.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced state flips and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES cycles never change the state.
- Press event: debounced state 0->1. Releases produce no event.
- Acceptance, evaluated in the cycle of the event:
  - lock=1 -> discard, reject=1 next cycle.
  - Pending flag of that channel already set -> discard, reject=1 next cycle.
  - Otherwise set pending flag.
  - Multiple discards in one cycle -> a single reject pulse.
- lock is sampled only at event time. Coins already pending are delivered even if lock rises afterwards.
- Arbiter FSM, states IDLE, PULSE, GAP:
  - IDLE: if any pending, go to PULSE. Assert exactly one output, priority 200 > 100 > 50, and clear that pending flag.
  - PULSE lasts 1 cycle, then GAP (1 cycle, all outputs 0), then IDLE.
  - Pulses are therefore one-hot, 1 cycle wide, and separated by >=2 low cycles.
- Outputs are registered; no combinational path from any input to any output.
- Latency, uncontended, lock=0: a clean press stable from edge k produces a pulse high during the cycle after edge k+DEBOUNCE_CYCLES+3.
- Simultaneous presses: all become pending in the same cycle and are delivered in priority order, one per 3-cycle slot.
- A button held through reset release is seen as a fresh press and yields one pulse after debounce.
- Reset mid-operation drops all pending coins; no pulse is emitted for them.

Optional Feature:
- Macro COIN_COUNT_EN.
- Defined: adds outputs cnt_50, cnt_100, cnt_200 (8-bit each).
  - Each counts pulses emitted on its channel.
  - Saturates at 255; reset to 0 by rst_n.
  - Counter updates in the same cycle the pulse is registered.
- Undefined: ports and logic absent; the remaining behaviour is identical.

Test Plan:
- CLK_FREQ=1000, DEBOUNCE_MS=4 (DEBOUNCE_CYCLES=4), BTN_ACTIVE_LOW=1, lock=0. Press btn_100 (drive 0) and hold 20 cycles -> exactly one r100 pulse, 1 cycle wide, at latency DEBOUNCE_CYCLES+3. r50, r200, reject stay 0. Release -> no further pulse.
- Bounce btn_50 0/1 every 2 cycles for 12 cycles, then hold 0 -> no pulse during bouncing; one r50 after the stable hold exceeds 4 cycles.
- Press btn_50, btn_100 and btn_200 on the same edge -> r200, then r100, then r50, each 1 cycle, spaced 3 cycles apart, never two high together.
- lock=1, press btn_200 -> reject pulses once and r200 never asserts. Set lock=0 and press again -> r200 pulses.
- Press btn_100, then assert rst_n=0 for 2 cycles before the pulse would appear -> no r100. After reset all outputs are 0; a new press yields a normal pulse.
- With COIN_COUNT_EN, press 50 three times and 200 once -> cnt_50=3, cnt_200=1, cnt_100=0. Force 256 r50 pulses -> cnt_50 holds at 255.
